// File: rtl/fpm_seq_if.sv
// Handshake and operand/result bus of the sequential floating-point multiplier.
interface fpm_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         additional1;
  logic         additional2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         additionalout;
  logic         overflow;
  logic         underflow;

  modport master (
    output in_valid, in1, in2, additional1, additional2, out_ready,
    input  in_ready, out_valid, out, additionalout, overflow, underflow
  );

  modport slave (
    input  in_valid, in1, in2, additional1, additional2, out_ready,
    output in_ready, out_valid, out, additionalout, overflow, underflow
  );
endinterface

// File: rtl/fpm_seq.sv
// Sequential floating-point multiplier: radix-2 shift-add over the M-bit
// significands, then normalise, truncate and saturate to overflow/underflow.
module fpm_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic       clk,
  input logic       rst,
  fpm_seq_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(M);
  localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic                   sign_p0;
  logic signed [XW-1:0]   exp_p0;
  logic [M-1:0]           mcand_p0;
  logic [2*M-1:0]         prod_p1;
  logic [M:0]             sum_p1;

  logic [MAN_W-1:0]       man_n;
  logic signed [XW-1:0]   exp_n;

  logic [W-1:0] out_q;
  logic         addl_q, ovf_q, unf_q;

  logic accept, nonzero;

  // Returns {overflow, underflow, hidden bit, packed word}.
  function automatic logic [W+2:0] saturate(input logic s,
                                            input logic signed [XW-1:0] e,
                                            input logic [MAN_W-1:0] m);
    if (e >= EXP_MAX)
      return {1'b1, 1'b0, 1'b1, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= EXP_ZERO)
      return {1'b0, 1'b1, 1'b0, s, {(W-1){1'b0}}};
    else
      return {1'b0, 1'b0, 1'b1, s, e[EXP_W-1:0], m};
  endfunction

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign nonzero = bus.additional1 & bus.additional2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == MUL) ? cnt_q + CW'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = nonzero ? MUL : DONE;
      MUL:     if (cnt_q == CW'(M - 1)) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0: operand capture; p1: one multiplier bit retired per MUL edge
  assign sum_p1 = {1'b0, prod_p1[2*M-1:M]} + (prod_p1[0] ? {1'b0, mcand_p0} : '0);

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_p0  <= bus.in1[W-1] ^ bus.in2[W-1];
      exp_p0   <= $signed({2'b00, bus.in1[W-2:MAN_W]}) + $signed({2'b00, bus.in2[W-2:MAN_W]}) - BIAS;
      mcand_p0 <= {bus.additional1, bus.in1[MAN_W-1:0]};
      prod_p1  <= {{M{1'b0}}, bus.additional2, bus.in2[MAN_W-1:0]};
    end else if (state_q == MUL) begin
      prod_p1  <= {sum_p1, prod_p1[M-1:1]};
    end
  end

  // p2: normalise the product, then truncate and saturate
  always_comb begin
    man_n = prod_p1[2*M-3:M-1];
    exp_n = exp_p0;
    if (prod_p1[2*M-1]) begin
      man_n = prod_p1[2*M-2:M];
      exp_n = exp_p0 + EXP_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {ovf_q, unf_q, addl_q, out_q} <= '0;
    end else if (accept && !nonzero) begin
      {ovf_q, unf_q, addl_q, out_q} <= '0;
    end else if (state_q == NORM) begin
      {ovf_q, unf_q, addl_q, out_q} <= saturate(sign_p0, exp_n, man_n);
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out           = out_q;
  assign bus.additionalout = addl_q;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = unf_q;
endmodule

// File: tb/tb_fpm_seq.sv
// Table-driven bench for fpm_seq with a result scoreboard and hand-written
// sequences for output hold and reset during multiplication.
module tb_fpm_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fpm_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fpm_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        a1;
    logic        a2;
    logic [31:0] word;
    logic        addl;
    logic        ovf;
    logic        unf;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        addl;
    logic        ovf;
    logic        unf;
  } exp_t;

  vec_t tbl [17];
  exp_t sb [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in1         = v.a;
    bus.in2         = v.b;
    bus.additional1 = v.a1;
    bus.additional2 = v.a2;
  endtask

  // Issue one operation, wait for the result and compare it against the scoreboard.
  task automatic run_op(input string name, input vec_t v, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    logic [34:0] held;
    @(negedge clk);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    e.word = v.word; e.addl = v.addl; e.ovf = v.ovf; e.unf = v.unf;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), (v.a1 & v.a2) ? 64'd25 : 64'd0);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check({name, "_result"}, {bus.out, bus.additionalout, bus.overflow, bus.underflow},
            {got.word, got.addl, got.ovf, got.unf});
    end
    held = {bus.out, bus.additionalout, bus.overflow, bus.underflow};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      drive(tbl[0]);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check($sformatf("%s_hold%0d_result", name, k),
            {bus.out, bus.additionalout, bus.overflow, bus.underflow}, held);
      check($sformatf("%s_hold%0d_ctl", name, k), {bus.out_valid, bus.in_ready}, 2'b10);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = (hold > 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({name, "_release"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    tbl[0]  = '{32'h40000000, 32'h40400000, 1'b1, 1'b1, 32'h40C00000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 1'b1, 32'h40100000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{32'hC0000000, 32'h40400000, 1'b1, 1'b1, 32'hC0C00000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'h40000000, 32'h40400000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'hC0000000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'h7F000000, 32'h7F000000, 1'b1, 1'b1, 32'h7F800000, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{32'h00800000, 32'h00800000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{32'h3F800000, 32'h3F800000, 1'b1, 1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{32'hFF000000, 32'h3F800000, 1'b1, 1'b1, 32'hFF000000, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{32'h7F000000, 32'h40000000, 1'b1, 1'b1, 32'h7F800000, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{32'hFF000000, 32'h40000000, 1'b1, 1'b1, 32'hFF800000, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{32'h00800000, 32'h3F000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{32'h80800000, 32'h3F000000, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{32'h7F400000, 32'h3FC00000, 1'b1, 1'b1, 32'h7F800000, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{32'h00C00000, 32'h3F400000, 1'b1, 1'b1, 32'h00900000, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 1'b1, 32'h407FFFFE, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{32'h3F800001, 32'h3F800001, 1'b1, 1'b1, 32'h3F800002, 1'b1, 1'b0, 1'b0};

    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.in1         = '0;
    bus.in2         = '0;
    bus.additional1 = 1'b0;
    bus.additional2 = 1'b0;

    #12;
    check("reset_ctl", {bus.in_ready, bus.out_valid}, 2'b10);
    check("reset_outs", {bus.out, bus.additionalout, bus.overflow, bus.underflow}, 35'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      run_op($sformatf("vec%0d", i), tbl[i], 0);

    // Result held for 5 cycles with in_valid pulses that must be ignored.
    run_op("hold", tbl[1], 5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_no_accept%0d", k), {bus.out_valid, bus.in_ready}, 2'b01);
    end

    // Reset asserted between edges at multiplier step 10.
    @(negedge clk);
    drive(tbl[2]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midmul_rst_ctl", {bus.in_ready, bus.out_valid}, 2'b10);
    check("midmul_rst_outs", {bus.out, bus.additionalout, bus.overflow, bus.underflow}, 35'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midmul_no_stale", {bus.out_valid, bus.in_ready}, 2'b01);
    run_op("after_rst", tbl[0], 0);
    run_op("after_rst_neg", tbl[12], 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
